// File: rtl/cache_axi_pkg.sv
// Shared constants and types for the L2 data-cache <-> AXI-like port bridges
// (refill and write-back paths).
package cache_axi_pkg;

   localparam int DATA_W     = 64;
   localparam int BEATS      = 4;
   localparam int LINE_W     = DATA_W * BEATS;
   localparam int BEAT_BYTES = DATA_W / 8;
   localparam int LINE_BYTES = BEAT_BYTES * BEATS;

   localparam logic [63:0] LINE_MASK = ~64'(LINE_BYTES - 1);
   localparam logic [1:0]  LAST_BEAT = 2'(BEATS - 1);

   typedef logic [BEATS-1:0][DATA_W-1:0]     line_t;
   typedef logic [BEATS-1:0][BEAT_BYTES-1:0] strb_t;

   typedef enum logic [1:0] {IDLE, SEL, BEAT, DONE} wb_state_e;

   // The base is line aligned, so a beat offset never carries out of bits [4:3].
   function automatic logic [63:0] beat_addr(input logic [63:0] base, input logic [1:0] idx);
      return base + {59'd0, idx, 3'd0};
   endfunction

endpackage

// File: rtl/dcache_wb_axi_if.sv
// Single-beat AXI-like write channel: the master presents a beat with AXI_WREQ,
// the slave accepts it with AXI_WASK.
interface dcache_wb_axi_if;
   import cache_axi_pkg::*;

   logic                  AXI_WREQ;
   logic                  AXI_WASK;
   logic [63:0]           AXI_WADDR;
   logic [DATA_W-1:0]     AXI_WDATA;
   logic [BEAT_BYTES-1:0] AXI_WMASK;

   modport master (
      output AXI_WREQ, AXI_WADDR, AXI_WDATA, AXI_WMASK,
      input  AXI_WASK
   );

   modport slave (
      input  AXI_WREQ, AXI_WADDR, AXI_WDATA, AXI_WMASK,
      output AXI_WASK
   );

endinterface

// File: rtl/wb_beat_sel.sv
// Priority finder: lowest beat index >= start whose byte-strobe slice is nonzero.
// Kept standalone so an uncached store path can reuse it.
module wb_beat_sel
   import cache_axi_pkg::*;
(
   input  strb_t      strb,
   input  logic [1:0] start,
   output logic       found,
   output logic [1:0] idx
);

   // Scan from the top down so the lowest qualifying index is the last one written.
   always_comb begin
      found = 1'b0;
      idx   = start;
      for (int k = BEATS - 1; k >= 0; k--) begin
         if (k >= int'(start) && strb[k] != '0) begin
            found = 1'b1;
            idx   = 2'(k);
         end
      end
   end

endmodule

// File: rtl/dcache_wb_axi.sv
// Write-back bridge: drains one dirty cache line as up to BEATS single-beat writes
// in ascending address order, skipping clean beats, then pulses l2_dcache_wask.
module dcache_wb_axi
   import cache_axi_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  dcache_l2_wreq,
   input  logic [63:0]           dcache_l2_waddr,
   input  logic [LINE_W-1:0]     dcache_l2_wdata,
   input  logic [LINE_BYTES-1:0] dcache_l2_wstrb,
   output logic                  l2_dcache_wask,
   output logic                  l2_dcache_busy,
   dcache_wb_axi_if.master       axi
);

   wb_state_e             state_q, state_d;
   logic [1:0]            idx_q, idx_d;
   logic [63:0]           base_q, base_d;
   line_t                 data_q, data_d;
   strb_t                 strb_q, strb_d;

   logic                  wreq_q, wreq_d;
   logic [63:0]           waddr_q, waddr_d;
   logic [DATA_W-1:0]     wdata_q, wdata_d;
   logic [BEAT_BYTES-1:0] wmask_q, wmask_d;
   logic                  wask_q, wask_d;
   logic                  busy_q, busy_d;

   logic                  load_beat;
   logic                  finish;
   logic [1:0]            search_start;
   logic                  sel_found;
   logic [1:0]            sel_idx;

   // In BEAT the current beat is already on the bus, so look past it.
   assign search_start = (state_q == BEAT) ? idx_q + 2'd1 : idx_q;

   wb_beat_sel u_beat_sel (
      .strb  (strb_q),
      .start (search_start),
      .found (sel_found),
      .idx   (sel_idx)
   );

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      base_d    = base_q;
      data_d    = data_q;
      strb_d    = strb_q;
      wreq_d    = wreq_q;
      waddr_d   = waddr_q;
      wdata_d   = wdata_q;
      wmask_d   = wmask_q;
      wask_d    = 1'b0;
      busy_d    = busy_q;
      load_beat = 1'b0;
      finish    = 1'b0;

      case (state_q)
         IDLE: begin
            if (dcache_l2_wreq) begin
               base_d  = dcache_l2_waddr & LINE_MASK;
               data_d  = dcache_l2_wdata;
               strb_d  = dcache_l2_wstrb;
               idx_d   = 2'd0;
               busy_d  = 1'b1;
               state_d = SEL;
            end
         end
         SEL: begin
            if (sel_found) begin
               load_beat = 1'b1;
            end else begin
               finish = 1'b1;
            end
         end
         BEAT: begin
            if (wreq_q && axi.AXI_WASK) begin
               if (idx_q != LAST_BEAT && sel_found) begin
                  load_beat = 1'b1;
               end else begin
                  finish = 1'b1;
               end
            end
         end
         DONE: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // A following beat replaces an accepted one in the same edge, so bursts have no bubbles.
      if (load_beat) begin
         wreq_d  = 1'b1;
         idx_d   = sel_idx;
         waddr_d = beat_addr(base_q, sel_idx);
         wdata_d = data_q[sel_idx];
         wmask_d = strb_q[sel_idx];
         state_d = BEAT;
      end

      if (finish) begin
         wreq_d  = 1'b0;
         wask_d  = 1'b1;
         state_d = DONE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         base_q  <= '0;
         data_q  <= '0;
         strb_q  <= '0;
         wreq_q  <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
         wmask_q <= '0;
         wask_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         base_q  <= base_d;
         data_q  <= data_d;
         strb_q  <= strb_d;
         wreq_q  <= wreq_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
         wmask_q <= wmask_d;
         wask_q  <= wask_d;
         busy_q  <= busy_d;
      end
   end

   assign axi.AXI_WREQ   = wreq_q;
   assign axi.AXI_WADDR  = waddr_q;
   assign axi.AXI_WDATA  = wdata_q;
   assign axi.AXI_WMASK  = wmask_q;
   assign l2_dcache_wask = wask_q;
   assign l2_dcache_busy = busy_q;

endmodule

// File: doc/dcache_wb_axi.md
Name: dcache_wb_axi

Overview:
- Write-back bridge between the L2 data-cache victim path and the single-beat AXI-like master port.
- Takes a full 32-byte dirty line plus a per-byte dirty mask and emits up to four 64-bit write beats, in ascending address order.
- Each beat uses the AXI_WREQ/AXI_WASK handshake.
- Signals completion to the cache with a one-cycle acknowledge.
- Mirrors the refill path: the refill reads a line in, this block writes one out.

Parameters:
- DATA_W, 64, width of one bus beat in bits.
- BEATS, 4, beats per cache line.
- LINE_W, 256, line width in bits; must equal DATA_W*BEATS.
- LINE_MASK, ~64'h1F, address mask that aligns a request to a line boundary.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- dcache_l2_wreq  in  1  write-back request; level, held until l2_dcache_wask.
- dcache_l2_waddr  in  64  line address; low 5 bits ignored.
- dcache_l2_wdata  in  256  line data; beat k = bits [64k+63:64k].
- dcache_l2_wstrb  in  32  per-byte dirty mask; byte j covers wdata[8j+7:8j].
- l2_dcache_wask  out  1  one-cycle pulse: line fully written.
- l2_dcache_busy  out  1  high from request capture until the wask pulse, inclusive.
- AXI_WREQ  out  1  write beat valid.
- AXI_WASK  in  1  beat accepted by the slave.
- AXI_WADDR  out  64  beat address.
- AXI_WDATA  out  64  beat data.
- AXI_WMASK  out  8  beat byte strobes.

Behaviour:
- Interface: one clock, `clk`. Reset `rst` is synchronous and active-high.
- Reset values: all outputs 0. Internal state returns to IDLE and the beat index to 0.
- A reset mid-burst drops AXI_WREQ at that same edge. No completion pulse is produced.
- All bus outputs are registered.
- Beat acceptance: AXI_WREQ && AXI_WASK sampled high at a rising edge.
- While AXI_WREQ is high and not yet accepted, AXI_WADDR, AXI_WDATA and AXI_WMASK stay stable.
- States: IDLE, SEL, BEAT, DONE.
- IDLE:
  - When dcache_l2_wreq is high, capture waddr&LINE_MASK, wdata and wstrb into internal line buffers.
  - Set beat index to 0 and busy to 1, then go to SEL.
  - The inputs are not sampled again until the next IDLE.
- SEL (one cycle, combinationally picks the next beat):
  - Find the lowest beat index i ≥ current index whose 8-bit strobe slice is nonzero.
  - If found: register AXI_WREQ=1, AXI_WADDR=base+8*i, AXI_WDATA=beat i, AXI_WMASK=strobe slice i; go to BEAT.
  - If none: go to DONE. A fully clean line therefore produces zero bus beats.
- BEAT:
  - On acceptance, if i == BEATS-1, drop AXI_WREQ and go to DONE.
  - Otherwise search from i+1 with the same rule. If a dirty beat is found, load it with AXI_WREQ still high (back-to-back, no bubble) and stay in BEAT.
  - If no further dirty beat exists, drop AXI_WREQ and go to DONE.
- DONE:
  - Assert l2_dcache_wask for exactly this one cycle, with busy still 1. Next state IDLE, busy 0.
  - A wreq still high in that cycle is ignored. The requester must drop wreq on seeing wask.
- Latency:
  - Full line with an always-ready slave: beats issued at cycles 2,3,4,5 after capture; wask at cycle 6.
  - Clean line: wask at cycle 2 after capture.
  - Each slave stall cycle adds one cycle.
- Address arithmetic is 64-bit with no wrap inside a line. The base is aligned, so beat offsets never carry out of bits [4:3].
- AXI_WASK while AXI_WREQ is low is ignored.
- The search is combinational over BEATS slices; its cost is bounded by BEATS.

Decomposition:
- Shared package cache_axi_pkg:
  - BEAT_BYTES=8, LINE_BYTES=32, BEATS=4, LINE_MASK.
  - typedef line_t (logic [3:0][63:0]).
  - typedef strb_t (logic [3:0][7:0]).
  - enum wb_state_e {IDLE,SEL,BEAT,DONE}.
- Natural sub-module: wb_beat_sel, a priority finder. Inputs: strb_t and a start index. Outputs: a found flag and a 2-bit index. It is reusable by a future uncached store path.

Test Plan:
- Full dirty line, addr 0x8000_0047, wstrb 0xFFFF_FFFF, WASK always 1:
  - Beats at 0x8000_0040/48/50/58 with WMASK 0xFF each and data words 0..3 in order.
  - Back-to-back, with one wask pulse the cycle after the last acceptance.
- Sparse mask wstrb 0x0F00_00F0, addr 0x1000:
  - Exactly two beats: 0x1000 with mask 0xF0, then 0x1018 with mask 0x0F.
  - Beats 1 and 2 are never driven, followed by a single wask.
- Clean line, wstrb 0: AXI_WREQ never rises; wask 2 cycles after the request is captured.
- Slave stalls with WASK low for 3 cycles on beat 1:
  - AXI_WADDR, AXI_WDATA and AXI_WMASK stay stable throughout the stall.
  - Total latency grows by 3 and no beat is duplicated or skipped.
- rst asserted while beat 2 awaits WASK:
  - Next cycle all outputs are 0 and no wask is issued.
  - A fresh request afterwards starts again at beat 0.
- Input change mid-burst and held request:
  - Changing wdata/waddr mid-burst has no effect on emitted beats.
  - wreq held high through DONE does not start a second write-back until one IDLE cycle has passed.
